// File: rtl/fft_input_buffer.sv
// Gathers eight complex samples into a bank, then hands them to the butterfly stage as one parallel frame.
// Optional macro FFT_IN_BITREV_EN: on transfer, slot k lands at signal_o[bitrev3(k)] instead of signal_o[k].
module fft_input_buffer #(
    parameter int W = 25
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           s_valid_i,
    output logic           s_ready_o,
    input  logic [2*W-1:0] s_data_i,
    output logic [2*W-1:0] signal_o [7:0],
    output logic           frame_valid_o,
    input  logic           frame_ready_i,
    output logic [15:0]    frame_cnt_o
);

    localparam logic [3:0] WR_FULL = 4'd8;
    localparam logic [3:0] WR_LAST = 4'd7;

    // Slot that feeds output position pos; bit reversal is its own inverse.
    function automatic int slot_of(input int pos);
        logic [2:0] b;
        b = 3'(pos);
`ifdef FFT_IN_BITREV_EN
        return int'({b[0], b[1], b[2]});
`else
        return int'(b);
`endif
    endfunction

    logic [2*W-1:0] bank_reg   [0:7];
    logic [2*W-1:0] frame_next [0:7];
    logic [2*W-1:0] signal_reg [0:7];

    logic [3:0]  wr_cnt_reg;
    logic [3:0]  wr_cnt_next;
    logic        s_ready_reg;
    logic        frame_valid_reg;
    logic        frame_valid_next;
    logic [15:0] frame_cnt_reg;

    logic accept;
    logic last_accept;
    logic slot_free;
    logic bank_full;
    logic transfer;
    logic handshake;

    always_comb begin
        accept      = s_valid_i && s_ready_reg;
        last_accept = accept && (wr_cnt_reg == WR_LAST);
        bank_full   = (wr_cnt_reg == WR_FULL);
        slot_free   = !frame_valid_reg || frame_ready_i;
        transfer    = slot_free && (last_accept || bank_full);
        handshake   = frame_valid_reg && frame_ready_i;
    end

    // Slot 7 bypasses the bank when the frame completes straight into a free output slot.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_frame_bank
            assign frame_next[gi] = bank_reg[gi];
        end
    endgenerate
    assign frame_next[7] = bank_full ? bank_reg[7] : s_data_i;

    always_comb begin
        wr_cnt_next = wr_cnt_reg;
        if (transfer) begin
            wr_cnt_next = 4'd0;
        end else if (last_accept) begin
            wr_cnt_next = WR_FULL;
        end else if (accept) begin
            wr_cnt_next = wr_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        frame_valid_next = frame_valid_reg;
        if (transfer) begin
            frame_valid_next = 1'b1;
        end else if (handshake) begin
            frame_valid_next = 1'b0;
        end
    end

    // Sample storage carries no reset: wr_cnt alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            bank_reg[wr_cnt_reg[2:0]] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_cnt_reg      <= 4'd0;
            s_ready_reg     <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_cnt_reg   <= 16'd0;
        end else begin
            wr_cnt_reg      <= wr_cnt_next;
            s_ready_reg     <= (wr_cnt_next != WR_FULL);
            frame_valid_reg <= frame_valid_next;
            if (handshake) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 8; i++) begin
                signal_reg[i] <= '0;
            end
        end else if (transfer) begin
            for (int i = 0; i < 8; i++) begin
                signal_reg[i] <= frame_next[slot_of(i)];
            end
        end
    end

    generate
        for (gi = 0; gi < 8; gi++) begin : g_signal_out
            assign signal_o[gi] = signal_reg[gi];
        end
    endgenerate

    assign s_ready_o     = s_ready_reg;
    assign frame_valid_o = frame_valid_reg;
    assign frame_cnt_o   = frame_cnt_reg;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed bench for fft_input_buffer: framing, back-pressure, streaming, reset and counter wrap.
module tb_fft_input_buffer;

    localparam int W = 25;

    logic           clk_i;
    logic           reset_i;
    logic           s_valid_i;
    logic           s_ready_o;
    logic [2*W-1:0] s_data_i;
    logic [2*W-1:0] signal_o [7:0];
    logic           frame_valid_o;
    logic           frame_ready_i;
    logic [15:0]    frame_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;
    int cnt0;

    fft_input_buffer #(.W(W)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data_i),
        .signal_o      (signal_o),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (frame_ready_i),
        .frame_cnt_o   (frame_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] mk(input int re, input int im);
        logic [W-1:0] rp;
        logic [W-1:0] ip;
        rp = W'(re);
        ip = W'(im);
        return {rp, ip};
    endfunction

    // Expected output position of slot k.
    function automatic int dst(input int k);
        logic [2:0] b;
        b = 3'(k);
`ifdef FFT_IN_BITREV_EN
        return int'({b[0], b[1], b[2]});
`else
        return int'(b);
`endif
    endfunction

    // Drives one sample; it is accepted on the posedge following return.
    task automatic send(input logic [2*W-1:0] d);
        int waitc;
        @(negedge clk_i);
        s_valid_i = 1'b1;
        s_data_i  = d;
        waitc = 0;
        while (!s_ready_o && waitc < 50) begin
            stalls++;
            @(negedge clk_i);
            waitc++;
        end
        if (waitc >= 50) check("send_timeout", 64'(s_ready_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i       = 1'b0;
        s_valid_i     = 1'b0;
        s_data_i      = '0;
        frame_ready_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_s_ready", 64'(s_ready_o), 64'd0);
        check("rst_fvalid", 64'(frame_valid_o), 64'd0);
        check("rst_fcnt", 64'(frame_cnt_o), 64'd0);
        check("rst_sig0", 64'(signal_o[0]), 64'd0);
        check("rst_sig7", 64'(signal_o[7]), 64'd0);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_ready", 64'(s_ready_o), 64'd1);

        // One frame with the consumer always ready
        frame_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) send(mk(k + 1, -(k + 1)));
        check("a_fvalid_early", 64'(frame_valid_o), 64'd0);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        check("a_fvalid", 64'(frame_valid_o), 64'd1);
        for (int k = 0; k < 8; k++) begin
            $display("frame A slot %0d -> signal_o[%0d] = %0h", k, dst(k), signal_o[dst(k)]);
            check($sformatf("a_sig_slot%0d", k), 64'(signal_o[dst(k)]), 64'(mk(k + 1, -(k + 1))));
        end
        @(negedge clk_i);
        check("a_fcnt", 64'(frame_cnt_o), 64'd1);
        check("a_fvalid_clr", 64'(frame_valid_o), 64'd0);

        // Back-pressure: two frames with the consumer stalled
        frame_ready_i = 1'b0;
        for (int k = 0; k < 16; k++) send(mk(32 + k, -(32 + k)));
        @(negedge clk_i);
        s_valid_i = 1'b0;
        check("b_ready_full", 64'(s_ready_o), 64'd0);
        check("b_fvalid", 64'(frame_valid_o), 64'd1);
        check("b_hold_slot0", 64'(signal_o[dst(0)]), 64'(mk(32, -32)));
        check("b_hold_slot7", 64'(signal_o[dst(7)]), 64'(mk(39, -39)));
        frame_ready_i = 1'b1;
        @(negedge clk_i);
        frame_ready_i = 1'b0;
        check("b_fvalid_kept", 64'(frame_valid_o), 64'd1);
        check("b_ready_back", 64'(s_ready_o), 64'd1);
        check("b_new_slot0", 64'(signal_o[dst(0)]), 64'(mk(40, -40)));
        check("b_new_slot7", 64'(signal_o[dst(7)]), 64'(mk(47, -47)));
        check("b_fcnt", 64'(frame_cnt_o), 64'd2);
        frame_ready_i = 1'b1;
        @(negedge clk_i);
        check("b_fcnt2", 64'(frame_cnt_o), 64'd3);
        check("b_fvalid_clr", 64'(frame_valid_o), 64'd0);

        // Continuous stream of 80 samples
        cnt0   = int'(frame_cnt_o);
        stalls = 0;
        for (int k = 0; k < 80; k++) send(mk(768 + k, -k));
        @(negedge clk_i);
        s_valid_i = 1'b0;
        check("c_last_slot7", 64'(signal_o[dst(7)]), 64'(mk(768 + 79, -79)));
        @(negedge clk_i);
        check("c_stalls", 64'(stalls), 64'd0);
        check("c_frames", 64'(int'(frame_cnt_o) - cnt0), 64'd10);

        // Reset in the middle of a frame
        frame_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) send(mk(85, 85));
        @(negedge clk_i);
        s_valid_i = 1'b0;
        reset_i   = 1'b0;
        #1;
        check("d_rst_ready", 64'(s_ready_o), 64'd0);
        check("d_rst_fcnt", 64'(frame_cnt_o), 64'd0);
        check("d_rst_fvalid", 64'(frame_valid_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int k = 0; k < 8; k++) send((2*W)'(256 + k));
        @(negedge clk_i);
        s_valid_i = 1'b0;
        check("d_fvalid", 64'(frame_valid_o), 64'd1);
        check("d_fcnt_pre", 64'(frame_cnt_o), 64'd0);
        for (int k = 0; k < 8; k++)
            check($sformatf("d_sig_slot%0d", k), 64'(signal_o[dst(k)]), 64'(256 + k));
        frame_ready_i = 1'b1;
        @(negedge clk_i);
        check("d_fcnt_post", 64'(frame_cnt_o), 64'd1);

        // Frame counter wrap
        force dut.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut.frame_cnt_reg;
        for (int k = 0; k < 8; k++) send(mk(k, k));
        @(negedge clk_i);
        s_valid_i = 1'b0;
        check("e_fcnt_max", 64'(frame_cnt_o), 64'hFFFF);
        @(negedge clk_i);
        check("e_fcnt_wrap", 64'(frame_cnt_o), 64'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
